// File: rtl/seg_scan_display.sv
// seg_scan_display
// ----------------
// Multiplexed seven-segment driver for a common-anode display bank.
// A binary value captured on a load strobe is converted to DIGITS BCD
// digits by a sequential double-dabble engine (one input bit per cycle).
// The finished digits are then scanned onto a shared segment bus, one
// digit per refresh slot. Leading zeros are blanked, and values that do
// not fit in DIGITS decimal digits show dashes on every digit.
//
// Optional feature macro: SEGDISP_HEX_EN
//   When defined, a hex_mode input exists. A load with hex_mode=1 skips
//   the conversion and displays din nibble by nibble, with A-F glyphs.
//
// Parameters
//   DATA_W      binary input width (4..32)
//   DIGITS      number of display digits (1..8)
//   CLK_HZ      clk frequency
//   REFRESH_HZ  digit-slot rate; slot length is CLK_HZ/REFRESH_HZ cycles (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   din       in   [DATA_W-1:0] value to display
//   load      in   one-cycle capture strobe, honoured only while busy=0
//   hex_mode  in   hex display select (only with SEGDISP_HEX_EN)
//   busy      out  conversion/commit in progress
//   ovf       out  last loaded value did not fit the display
//   an        out  [DIGITS-1:0] digit enables, active low, one-hot-low
//   seg       out  [6:0] segments {a,b,c,d,e,f,g}, active low
module seg_scan_display #(
  parameter int DATA_W     = 8,
  parameter int DIGITS     = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
`ifdef SEGDISP_HEX_EN
  input  logic              hex_mode,
`endif
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int DIV    = CLK_HZ / REFRESH_HZ;
  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NSEL   = 1 << IDX_W;  // digit mux padded to a power of two
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BCD_W-1:0]  bcd_q, bcd_adj, bcd_d;
  logic              sticky_q, carry_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        digit_arr [NSEL];
  logic [NSEL-1:0]   zero_above;

  genvar gi;

  // Double-dabble step: add 3 to each nibble >= 5, then shift the whole
  // {carry, bcd, sreg} chain left by one. The carry is the bit leaving the
  // top nibble, which only happens once the value exceeds 10^DIGITS-1.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  assign {carry_d, bcd_d, sreg_d} = {bcd_adj, sreg_q, 1'b0};

`ifdef SEGDISP_HEX_EN
  logic [BCD_W-1:0] hex_digits;
  logic             hex_ovf;

  generate
    if (DATA_W > BCD_W) begin : g_hex_wide
      assign hex_digits = din[BCD_W-1:0];
      assign hex_ovf    = |din[DATA_W-1:BCD_W];
    end else begin : g_hex_narrow
      assign hex_digits = BCD_W'(din);
      assign hex_ovf    = 1'b0;
    end
  endgenerate
`endif

  // Conversion FSM. The display register is written only in COMMIT, so the
  // scan never sees a half-converted value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
`ifdef SEGDISP_HEX_EN
            if (hex_mode) begin
              bcd_q    <= hex_digits;
              sticky_q <= hex_ovf;
              state_q  <= COMMIT;
            end else
`endif
            begin
              sreg_q   <= din;
              bcd_q    <= '0;
              sticky_q <= 1'b0;
              cnt_q    <= CNT_W'(DATA_W);
              state_q  <= CONV;
            end
          end
        end
        CONV: begin
          sreg_q   <= sreg_d;
          bcd_q    <= bcd_d;
          sticky_q <= sticky_q | carry_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          disp_q  <= disp_d;
          ovf_q   <= ovf_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next-state display contents; seg/an are registered from these so a
  // slot change coinciding with COMMIT already shows the new value.
  assign disp_d = (state_q == COMMIT) ? bcd_q    : disp_q;
  assign ovf_d  = (state_q == COMMIT) ? sticky_q : ovf_q;

  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_sel
      if (gi < DIGITS) begin : g_real
        assign digit_arr[gi]  = disp_d[4*gi +: 4];
        assign zero_above[gi] = ~|disp_d[BCD_W-1:4*gi];
      end else begin : g_pad
        assign digit_arr[gi]  = 4'd0;
        assign zero_above[gi] = 1'b1;
      end
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
`ifdef SEGDISP_HEX_EN
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      4'hF:    seg_decode = 7'b0111000;
`endif
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    slot_d = slot_q + SLOT_W'(1);
    idx_d  = idx_q;
    if (slot_q == SLOT_W'(DIV - 1)) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Digit 0 is never blanked; higher digits blank when they and every
  // digit above them are zero.
  always_comb begin
    if (ovf_d) begin
      seg_d = 7'b1111110;
    end else if ((idx_d != '0) && zero_above[idx_d]) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_decode(digit_arr[idx_d]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= '0;
      an_q   <= ~DIGITS'(1);
      seg_q  <= 7'b0000001;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      an_q   <= ~(DIGITS'(1) << idx_d);
      seg_q  <= seg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
// Self-checking bench for seg_scan_display (DATA_W=16, DIGITS=4, DIV=4).
// The reference model keeps the displayed integer and derives every
// expected digit, blanking and dash pattern with plain division, and the
// scanned digit from the number of clocks since reset.
module tb_seg_scan_display;

  localparam int DATA_W     = 16;
  localparam int DIGITS     = 4;
  localparam int CLK_HZ     = 8;
  localparam int REFRESH_HZ = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;
  localparam int SWEEP      = DIV * DIGITS;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              load  = 1'b0;
  logic [DATA_W-1:0] din   = '0;
`ifdef SEGDISP_HEX_EN
  logic              hex_mode = 1'b0;
`endif
  logic              busy, ovf;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  seg_scan_display #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
`ifdef SEGDISP_HEX_EN
    .hex_mode(hex_mode),
`endif
    .busy(busy), .ovf(ovf), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Clocks since the last reset edge: drives the expected scan position.
  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Reference model of what the display should currently show.
  int unsigned m_val = 0;
  bit          m_ovf = 1'b0;
  bit          m_hex = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  logic [12:0] q_obs [$];  // {busy, ovf, an, seg}
  int          q_cyc [$];

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [DIGITS-1:0] exp_an(input int c);
    logic [DIGITS-1:0] r;
    r = '1;
    r[(c / DIV) % DIGITS] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int c);
    int unsigned idx, base, rest;
    idx  = (c / DIV) % DIGITS;
    base = m_hex ? 16 : 10;
    rest = m_val;
    if (m_ovf) return 7'b1111110;
    for (int k = 0; k < int'(idx); k++) rest = rest / base;
    if (idx > 0 && rest == 0) return 7'b1111111;
    return seg_code(4'(rest % base));
  endfunction

  task automatic observe();
    q_obs.push_back({busy, ovf, an, seg});
    q_cyc.push_back(cyc);
  endtask

  task automatic sweep(input int n);
    q_obs.delete();
    q_cyc.delete();
    repeat (n) begin
      observe();
      @(negedge clk);
    end
  endtask

  // Called at a negedge: pulses load with v, then records outputs while
  // busy is high (bounded). Optionally re-asserts load with extra_v at the
  // extra_at-th busy cycle. Returns at the first negedge with busy low.
  task automatic run_load(input logic [DATA_W-1:0] v, input int extra_at,
                          input logic [DATA_W-1:0] extra_v,
                          output int nbusy, output bit started);
    din  = v;
    load = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    din     = DATA_W'($urandom);
    started = (busy === 1'b1);
    nbusy   = 0;
    q_obs.delete();
    q_cyc.delete();
    while (busy === 1'b1 && nbusy < 200) begin
      observe();
      nbusy++;
      if (nbusy == extra_at) begin
        din  = extra_v;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, ovf, an, seg} !== {1'b0, 1'b0, 4'b1110, 7'b0000001}) begin
      n_bad++;
      $display("FAIL reset_state got busy,ovf,an,seg=%b required %b",
               {busy, ovf, an, seg}, {1'b0, 1'b0, 4'b1110, 7'b0000001});
    end
    rst_n = 1'b1;
    m_val = 0; m_ovf = 1'b0; m_hex = 1'b0;
    sweep(2 * SWEEP);
    for (int j = 0; j < q_obs.size(); j++) begin
      e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
      n_vec++;
      if (q_obs[j] !== e) begin
        n_bad++;
        $display("FAIL reset_scan cyc=%0d got %b required %b", q_cyc[j], q_obs[j], e);
      end
    end
  endtask

  task automatic test_decimal_fixed();
    logic [DATA_W-1:0] vals [4] = '{16'd255, 16'd12345, 16'd9999, 16'd10000};
    logic [12:0] e;
    int nb;
    bit st;
    foreach (vals[k]) begin
      run_load(vals[k], 0, '0, nb, st);
      n_vec++;
      if (!st || nb != DATA_W + 1) begin
        n_bad++;
        $display("FAIL busy_len val=%0d got start=%0b cycles=%0d required start=1 cycles=%0d",
                 vals[k], st, nb, DATA_W + 1);
      end
      for (int j = 0; j < q_obs.size(); j++) begin
        e = {1'b1, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
        n_vec++;
        if (q_obs[j] !== e) begin
          n_bad++;
          $display("FAIL stale_during_conv cyc=%0d got %b required %b", q_cyc[j], q_obs[j], e);
        end
      end
      m_val = vals[k]; m_ovf = (vals[k] > 9999); m_hex = 1'b0;
      sweep(SWEEP);
      for (int j = 0; j < q_obs.size(); j++) begin
        e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
        n_vec++;
        if (q_obs[j] !== e) begin
          n_bad++;
          $display("FAIL fixed_display val=%0d cyc=%0d got %b required %b",
                   vals[k], q_cyc[j], q_obs[j], e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] v;
    logic [12:0] e;
    int nb;
    bit st;
    for (int k = 0; k < 14; k++) begin
      case (k)
        0: v = 16'd0;
        1: v = 16'd9;
        2: v = 16'd10;
        3: v = 16'd65535;
        default: v = $urandom_range(0, 1) ? DATA_W'($urandom_range(0, 9999))
                                          : DATA_W'($urandom_range(0, 65535));
      endcase
      run_load(v, 0, '0, nb, st);
      n_vec++;
      if (!st || nb != DATA_W + 1) begin
        n_bad++;
        $display("FAIL rand_busy_len val=%0d got start=%0b cycles=%0d required start=1 cycles=%0d",
                 v, st, nb, DATA_W + 1);
      end
      m_val = v; m_ovf = (v > 9999); m_hex = 1'b0;
      sweep(SWEEP);
      for (int j = 0; j < q_obs.size(); j++) begin
        e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
        n_vec++;
        if (q_obs[j] !== e) begin
          n_bad++;
          $display("FAIL rand_display val=%0d cyc=%0d got %b required %b", v, q_cyc[j], q_obs[j], e);
        end
      end
    end
  endtask

  task automatic test_ignored_load();
    logic [12:0] e;
    int nb;
    bit st;
    run_load(16'd42, 3, 16'd7, nb, st);
    n_vec++;
    if (!st || nb != DATA_W + 1) begin
      n_bad++;
      $display("FAIL ignored_load_busy got start=%0b cycles=%0d required start=1 cycles=%0d",
               st, nb, DATA_W + 1);
    end
    m_val = 42; m_ovf = 1'b0; m_hex = 1'b0;
    sweep(2 * SWEEP);
    for (int j = 0; j < q_obs.size(); j++) begin
      e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
      n_vec++;
      if (q_obs[j] !== e) begin
        n_bad++;
        $display("FAIL ignored_load_display cyc=%0d got %b required %b", q_cyc[j], q_obs[j], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    logic [12:0] e;
    int nb;
    bit st;
    for (int k = 0; k < 4; k++) begin
      v = DATA_W'($urandom_range(0, 9999));
      run_load(v, 0, '0, nb, st);
      n_vec++;
      if (!st || nb != DATA_W + 1) begin
        n_bad++;
        $display("FAIL b2b_busy val=%0d got start=%0b cycles=%0d required start=1 cycles=%0d",
                 v, st, nb, DATA_W + 1);
      end
      for (int j = 0; j < q_obs.size(); j++) begin
        e = {1'b1, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
        n_vec++;
        if (q_obs[j] !== e) begin
          n_bad++;
          $display("FAIL b2b_previous cyc=%0d got %b required %b", q_cyc[j], q_obs[j], e);
        end
      end
      m_val = v; m_ovf = 1'b0; m_hex = 1'b0;
      e = {1'b0, m_ovf, exp_an(cyc), exp_seg(cyc)};
      n_vec++;
      if ({busy, ovf, an, seg} !== e) begin
        n_bad++;
        $display("FAIL b2b_first_idle val=%0d got %b required %b", v, {busy, ovf, an, seg}, e);
      end
    end
    sweep(1);
  endtask

  task automatic test_reset_mid_conv();
    logic [12:0] e;
    int nb;
    bit st;
    run_load(16'd50000, 0, '0, nb, st);
    m_val = 50000; m_ovf = 1'b1; m_hex = 1'b0;
    n_vec++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_ovf got %b required 1", ovf);
    end
    din  = 16'd200;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, ovf, an, seg} !== {1'b0, 1'b0, 4'b1110, 7'b0000001}) begin
      n_bad++;
      $display("FAIL mid_conv_reset got busy,ovf,an,seg=%b required %b",
               {busy, ovf, an, seg}, {1'b0, 1'b0, 4'b1110, 7'b0000001});
    end
    rst_n = 1'b1;
    m_val = 0; m_ovf = 1'b0;
    sweep(2 * SWEEP);
    for (int j = 0; j < q_obs.size(); j++) begin
      e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
      n_vec++;
      if (q_obs[j] !== e) begin
        n_bad++;
        $display("FAIL after_reset_display cyc=%0d got %b required %b", q_cyc[j], q_obs[j], e);
      end
    end
  endtask

`ifdef SEGDISP_HEX_EN
  task automatic test_hex();
    logic [DATA_W-1:0] v;
    logic [12:0] e;
    int nb;
    bit st;
    for (int k = 0; k < 6; k++) begin
      v = (k == 0) ? 16'h00AB : (k == 1) ? 16'h0000
                              : DATA_W'($urandom) >> (4 * $urandom_range(0, 3));
      hex_mode = 1'b1;
      run_load(v, 0, '0, nb, st);
      hex_mode = 1'b0;
      n_vec++;
      if (!st || nb != 1) begin
        n_bad++;
        $display("FAIL hex_busy val=%h got start=%0b cycles=%0d required start=1 cycles=1", v, st, nb);
      end
      m_val = v; m_ovf = 1'b0; m_hex = 1'b1;
      sweep(SWEEP);
      for (int j = 0; j < q_obs.size(); j++) begin
        e = {1'b0, m_ovf, exp_an(q_cyc[j]), exp_seg(q_cyc[j])};
        n_vec++;
        if (q_obs[j] !== e) begin
          n_bad++;
          $display("FAIL hex_display val=%h cyc=%0d got %b required %b", v, q_cyc[j], q_obs[j], e);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decimal_fixed();
    test_ignored_load();
    test_back_to_back();
    test_random();
    test_reset_mid_conv();
`ifdef SEGDISP_HEX_EN
    test_hex();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
